// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: loader FSM
// state encoding and the IMEM word/byte-address widths.
package imem_boot_loader_pkg;

   localparam int IMEM_WORD_W = 32;  // instruction word width
   localparam int IMEM_ADDR_W = 32;  // IMEM byte-address width
   localparam int BYTE_W      = 8;
   localparam int LEN_W       = 16;  // image length header, in words

   typedef enum logic [2:0] {
      ST_LEN_LO = 3'd0,
      ST_LEN_HI = 3'd1,
      ST_LOAD   = 3'd2,
      ST_DONE   = 3'd3,
      ST_ERR    = 3'd4
   } state_e;

   // Byte address of word idx in an image that starts at base.
   function automatic logic [IMEM_ADDR_W-1:0] word_byte_addr(
      input logic [IMEM_ADDR_W-1:0] base,
      input logic [LEN_W-1:0]       idx
   );
      return base + {{(IMEM_ADDR_W-LEN_W-2){1'b0}}, idx, 2'b00};
   endfunction

endpackage

// File: rtl/imem_boot_loader_byte_to_word_packer.sv
// Collects four bytes into one little-endian 32-bit word. The fourth byte
// is not stored: it is combined directly into o_word in the cycle it
// arrives, together with a one-cycle o_word_done pulse.
module imem_boot_loader_byte_to_word_packer
   import imem_boot_loader_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_clear,
   input  logic                   i_valid,
   input  logic [BYTE_W-1:0]      i_byte,
   output logic [IMEM_WORD_W-1:0] o_word,
   output logic                   o_word_done
);

   logic [1:0]  r_byte_idx;
   logic [23:0] r_lanes;

   // Lane shifter and mod-4 byte counter.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset || i_clear) begin
         r_byte_idx <= 2'd0;
         r_lanes    <= '0;
      end else if (i_valid) begin
         case (r_byte_idx)
            2'd0:    r_lanes[7:0]   <= i_byte;
            2'd1:    r_lanes[15:8]  <= i_byte;
            2'd2:    r_lanes[23:16] <= i_byte;
            default: ;  // lane 3 goes straight to o_word
         endcase
         r_byte_idx <= r_byte_idx + 2'd1;
      end
   end

   assign o_word      = {i_byte, r_lanes};
   assign o_word_done = i_valid && (r_byte_idx == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: takes a length-prefixed little-endian image over a byte
// valid/ready stream, writes it word by word into instruction memory, and
// holds the pipeline core in reset until the whole image is written.
module imem_boot_loader
   import imem_boot_loader_pkg::*;
#(
   parameter int                     IMEM_DEPTH_WORDS = 256,
   parameter logic [IMEM_ADDR_W-1:0] BASE_ADDR        = 32'h0
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [BYTE_W-1:0]      byte_data_i,
   input  logic                   byte_valid_i,
   output logic                   byte_ready_o,
   output logic [IMEM_WORD_W-1:0] wr_instr_imem_o,
   output logic [IMEM_ADDR_W-1:0] wr_addr_imem_o,
   output logic                   wr_en_imem_o,
   output logic                   core_reset_o,
   output logic                   load_done_o,
   output logic                   load_err_o,
   output logic [LEN_W-1:0]       words_loaded_o
);

   localparam logic [LEN_W:0] DEPTH_LIMIT = (LEN_W+1)'(IMEM_DEPTH_WORDS);

   state_e                 r_state;
   state_e                 w_next_state;
   logic [BYTE_W-1:0]      r_len_lo;
   logic [LEN_W-1:0]       r_len;
   logic [LEN_W-1:0]       r_word_idx;
   logic                   r_wr_en;
   logic [IMEM_WORD_W-1:0] r_wr_instr;
   logic [IMEM_ADDR_W-1:0] r_wr_addr;
   logic                   r_core_reset;
   logic                   r_load_done;
   logic                   r_load_err;

   logic [LEN_W-1:0]       w_len_full;
   logic                   w_hdr_lo_xfer;
   logic                   w_hdr_hi_xfer;
   logic                   w_load_xfer;
   logic                   w_word_done;
   logic                   w_last_word;
   logic [IMEM_WORD_W-1:0] w_word;

   // Ready is high in every accepting state, so a transfer in one of them
   // reduces to byte_valid_i.
   assign w_len_full    = {byte_data_i, r_len_lo};
   assign w_hdr_lo_xfer = byte_valid_i && (r_state == ST_LEN_LO);
   assign w_hdr_hi_xfer = byte_valid_i && (r_state == ST_LEN_HI);
   assign w_load_xfer   = byte_valid_i && (r_state == ST_LOAD);
   assign w_last_word   = (r_word_idx == (r_len - 16'd1));

   imem_boot_loader_byte_to_word_packer u_packer (
      .clk         (clk),
      .reset       (reset),
      .i_clear     (w_hdr_hi_xfer),
      .i_valid     (w_load_xfer),
      .i_byte      (byte_data_i),
      .o_word      (w_word),
      .o_word_done (w_word_done)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_LEN_LO;
      else       r_state <= w_next_state;
   end

   // Next-state decode, length check and byte_ready_o.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
      w_next_state = r_state;
      byte_ready_o = 1'b0;
      case (r_state)
         ST_LEN_LO: begin
            byte_ready_o = 1'b1;
            if (byte_valid_i) w_next_state = ST_LEN_HI;
         end
         ST_LEN_HI: begin
            byte_ready_o = 1'b1;
            if (byte_valid_i) begin
               if (w_len_full == '0)                     w_next_state = ST_DONE;
               else if ({1'b0, w_len_full} > DEPTH_LIMIT) w_next_state = ST_ERR;
               else                                       w_next_state = ST_LOAD;
            end
         end
         ST_LOAD: begin
            byte_ready_o = 1'b1;
            if (w_word_done && w_last_word) w_next_state = ST_DONE;
         end
         ST_DONE, ST_ERR: ;
         default: w_next_state = ST_LEN_LO;
      endcase
   end

   // Header capture, IMEM write port, word counter and status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_len_lo     <= '0;
         r_len        <= '0;
         r_word_idx   <= '0;
         r_wr_en      <= 1'b0;
         r_wr_instr   <= '0;
         r_wr_addr    <= BASE_ADDR;
         r_core_reset <= 1'b1;
         r_load_done  <= 1'b0;
         r_load_err   <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         if (w_hdr_lo_xfer) r_len_lo <= byte_data_i;
         if (w_hdr_hi_xfer) begin
            r_len      <= w_len_full;
            r_word_idx <= '0;
         end
         if (w_word_done) begin
            r_wr_en    <= 1'b1;
            r_wr_instr <= w_word;
            r_wr_addr  <= word_byte_addr(BASE_ADDR, r_word_idx);
            r_word_idx <= r_word_idx + 16'd1;
         end
         if (w_next_state == ST_DONE) r_load_done <= 1'b1;
         if (w_next_state == ST_ERR)  r_load_err  <= 1'b1;
         // Released only once DONE has been the current state for a cycle.
         r_core_reset <= (r_state != ST_DONE);
      end
   end

   assign wr_en_imem_o    = r_wr_en;
   assign wr_instr_imem_o = r_wr_instr;
   assign wr_addr_imem_o  = r_wr_addr;
   assign core_reset_o    = r_core_reset;
   assign load_done_o     = r_load_done;
   assign load_err_o      = r_load_err;
   assign words_loaded_o  = r_word_idx;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sits directly upstream of the pipelined MIPS core.
- Receives a program image as a byte stream over a valid/ready handshake.
- Assembles little-endian 32-bit instruction words and drives the instruction memory write port (write data, address, write enable) sequentially.
- Holds the core in reset until the image is fully written, then releases it. The core fetches from address BASE_ADDR on its first unreset cycle.

Parameters:
- IMEM_DEPTH_WORDS, 256, capacity of instruction memory in words; larger images are rejected.
- BASE_ADDR, 32'h0, byte address of the first word written.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset. Restarts the loader and re-asserts core reset.
- byte_data_i  input  8  incoming image byte.
- byte_valid_i  input  1  byte_data_i is valid.
- byte_ready_o  output  1  loader accepts a byte this cycle.
- wr_instr_imem_o  output  32  assembled instruction word.
- wr_addr_imem_o  output  32  byte address for the write.
- wr_en_imem_o  output  1  one-cycle instruction memory write strobe.
- core_reset_o  output  1  reset to the pipeline core, active-high.
- load_done_o  output  1  image fully loaded (sticky until reset).
- load_err_o  output  1  bad length header (sticky until reset).
- words_loaded_o  output  16  count of words written so far.

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - state = LEN_LO.
  - byte_ready_o = 1, wr_en_imem_o = 0, core_reset_o = 1.
  - load_done_o = 0, load_err_o = 0, words_loaded_o = 0.
  - wr_instr_imem_o = 0, wr_addr_imem_o = BASE_ADDR.
- A byte transfers in a cycle where byte_valid_i && byte_ready_o. No transfer means no state change.
- FSM states: LEN_LO, LEN_HI, LOAD, DONE, ERR.
- LEN_LO: on transfer, len[7:0] <= byte; go to LEN_HI.
- LEN_HI: on transfer, len[15:8] <= byte. Then evaluate the full 16-bit len:
  - len == 0 -> DONE.
  - len > IMEM_DEPTH_WORDS -> ERR.
  - otherwise -> LOAD, with byte_idx = 0 and word_idx = 0.
- LOAD, each transfer:
  - Shift the byte into the assembly register at lane byte_idx (byte 0 -> bits 7:0, little-endian); byte_idx increments mod 4.
  - On the transfer with byte_idx == 3, the next cycle drives:
    - wr_en_imem_o = 1 for exactly one cycle;
    - wr_instr_imem_o = assembled word;
    - wr_addr_imem_o = BASE_ADDR + 4*word_idx (32-bit arithmetic, wrap ignored).
  - In that same update, word_idx and words_loaded_o increment.
  - If that word was word len-1, go to DONE in the same edge as the write strobe.
- byte_ready_o:
  - High in LEN_LO, LEN_HI and LOAD, including the write-strobe cycle, so back-to-back bytes sustain 1 byte/clock.
  - Low in DONE and ERR.
- DONE: load_done_o = 1. core_reset_o = 0 from the cycle after DONE is entered. Bytes are ignored (ready low) until reset.
- ERR: load_err_o = 1, core_reset_o stays 1, no writes. Leave ERR only via reset.
- wr_instr_imem_o and wr_addr_imem_o hold their last values when wr_en_imem_o = 0.
- Reset mid-load: abandon the partial word, clear all counters, re-enter LEN_LO, core_reset_o = 1. Already-written memory contents are not cleared.
- A gap in byte_valid_i mid-word or mid-header preserves the partial assembly indefinitely; there is no timeout.
- Length boundaries:
  - len == IMEM_DEPTH_WORDS is accepted.
  - len == IMEM_DEPTH_WORDS+1 -> ERR.

Decomposition:
- Shared pipeline package holds the FSM state encoding (3-bit localparams LEN_LO..ERR) and the IMEM word/byte-address width constants used by the instruction memory.
- One natural sub-module: byte_to_word_packer (byte lane shifter, mod-4 counter, word-complete pulse). The top of the loader keeps the FSM, length check and address generation.

Test Plan:
- Reset, then stream 02 00, 13 00 00 20, 08 00 00 AC with valid held high. Required:
  - writes 0x20000013 @0x0, then 0xAC000008 @0x4, each a single-cycle wr_en;
  - load_done_o = 1 and words_loaded_o = 2;
  - core_reset_o falls one cycle after DONE is entered.
- Header 00 00 -> no wr_en; DONE immediately after the 2nd byte; core_reset_o low the following cycle.
- IMEM_DEPTH_WORDS = 256, header 01 01 (257) -> load_err_o = 1, byte_ready_o = 0, core_reset_o stays 1. Header 00 01 (256) loads 256 words, last at address 0x3FC.
- Random gaps on byte_valid_i inside a word and between header bytes -> identical write sequence and data to the gap-free run; no spurious wr_en.
- Assert reset after 2 bytes of word 1 with len = 3 -> counters and words_loaded_o = 0, FSM in LEN_LO; a fresh image of 1 word writes to BASE_ADDR.
- BASE_ADDR = 32'h400, len = 1 -> write address 0x400; bytes presented after DONE are not accepted (ready = 0) and cause no writes.
